// File: rtl/i2c_reg_bank_pkg.sv
// Shared types and constants for the I2C register-bank slice.
package i2c_pkg;

    localparam int unsigned DATA_W = 8;
    localparam logic [DATA_W-1:0] RD_OOR_VAL = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        WR_PTR,
        WR_DATA,
        RD
    } i2c_rb_state_t;

endpackage

// File: rtl/i2c_reg_bank_if.sv
// Bundles the I2C-subordinate event/byte signals and the local host port.
interface i2c_reg_bank_if import i2c_pkg::*; #(
    parameter int unsigned PTR_W = 8
);

    logic              start_det;
    logic              stop_det;
    logic              addr_match;
    logic              rw_bit;
    logic              rx_valid;
    logic [DATA_W-1:0] rx_byte;
    logic              tx_req;
    logic [DATA_W-1:0] tx_byte;
    logic              tx_valid;
    logic [PTR_W-1:0]  host_addr;
    logic              host_wr;
    logic [DATA_W-1:0] host_wdata;
    logic [DATA_W-1:0] host_rdata;
    logic              reg_wr_pulse;
    logic [PTR_W-1:0]  reg_wr_idx;
    logic              ptr_err;
    logic              host_conflict;

    // Driven by the I2C front end and the host; observed by them.
    modport master (
        output start_det, stop_det, addr_match, rw_bit, rx_valid, rx_byte, tx_req,
               host_addr, host_wr, host_wdata,
        input  tx_byte, tx_valid, host_rdata, reg_wr_pulse, reg_wr_idx, ptr_err,
               host_conflict
    );

    // The register bank itself.
    modport slave (
        input  start_det, stop_det, addr_match, rw_bit, rx_valid, rx_byte, tx_req,
               host_addr, host_wr, host_wdata,
        output tx_byte, tx_valid, host_rdata, reg_wr_pulse, reg_wr_idx, ptr_err,
               host_conflict
    );

endinterface

// File: rtl/i2c_reg_bank_array.sv
// NUM_REGS x 8 register storage: I2C write port (priority) plus host write port,
// combinational host read port and registered transmit read port.
module i2c_reg_array import i2c_pkg::*; #(
    parameter int unsigned       NUM_REGS  = 16,
    parameter int unsigned       PTR_W     = 8,
    parameter logic [DATA_W-1:0] RESET_VAL = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i2c_we,
    input  logic [PTR_W-1:0]  i2c_idx,
    input  logic [DATA_W-1:0] i2c_wdata,
    input  logic              host_we,
    input  logic [PTR_W-1:0]  host_idx,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic [PTR_W-1:0]  host_raddr,
    output logic [DATA_W-1:0] host_rdata_c,
    input  logic              tx_re,
    input  logic [PTR_W-1:0]  tx_idx,
    input  logic              tx_force_oor,
    output logic [DATA_W-1:0] tx_rdata,
    output logic              conflict
);

    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              i2c_ok_c;
    logic              host_ok_c;
    logic              collide_c;

    function automatic logic in_rng(input logic [PTR_W-1:0] idx);
        return 32'(idx) < NUM_REGS;
    endfunction

    // Out-of-range indices never reach storage; a same-index host write loses.
    always_comb begin
        i2c_ok_c  = i2c_we && in_rng(i2c_idx);
        host_ok_c = host_we && in_rng(host_idx);
        collide_c = i2c_ok_c && host_ok_c && (i2c_idx == host_idx);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= RESET_VAL;
            end
            tx_rdata <= '0;
            conflict <= 1'b0;
        end else begin
            conflict <= collide_c;
            if (host_ok_c && !collide_c) begin
                regs[IDX_W'(host_idx)] <= host_wdata;
            end
            if (i2c_ok_c) begin
                regs[IDX_W'(i2c_idx)] <= i2c_wdata;
            end
            // Samples pre-edge contents, so a same-cycle write returns the old value.
            if (tx_re) begin
                tx_rdata <= (tx_force_oor || !in_rng(tx_idx)) ? RD_OOR_VAL
                                                              : regs[IDX_W'(tx_idx)];
            end
        end
    end

    assign host_rdata_c = in_rng(host_raddr) ? regs[IDX_W'(host_raddr)] : RD_OOR_VAL;

endmodule

// File: rtl/i2c_reg_bank.sv
// Register bank behind the I2C subordinate: pointer/auto-increment protocol FSM
// in front of a shared register array that a local host can also access.
module i2c_reg_bank import i2c_pkg::*; #(
    parameter int unsigned       NUM_REGS  = 16,
    parameter int unsigned       PTR_W     = 8,
    parameter logic [DATA_W-1:0] RESET_VAL = 8'h00
) (
    input logic           clk,
    input logic           rst,
    i2c_reg_bank_if.slave bus
);

    localparam int unsigned LAST_IDX = NUM_REGS - 1;

    i2c_rb_state_t     state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              ptr_err_q, ptr_err_d;
    logic              wr_en_c;
    logic              rd_en_c;
    logic              tx_valid_q;
    logic              wr_pulse_q;
    logic [PTR_W-1:0]  wr_idx_q;
    logic [DATA_W-1:0] tx_rdata;
    logic [DATA_W-1:0] host_rdata_c;
    logic              conflict;

    // Wraps from the last register (or any stale out-of-range value) to zero.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (32'(p) >= LAST_IDX) ? '0 : p + PTR_W'(1);
    endfunction

    // START beats STOP; an address match restarts the transaction from any state.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        ptr_err_d = ptr_err_q;
        wr_en_c   = 1'b0;
        rd_en_c   = 1'b0;

        if (bus.start_det) begin
            state_d   = IDLE;
            ptr_err_d = 1'b0;
        end else if (bus.stop_det) begin
            state_d = IDLE;
        end else if (bus.addr_match) begin
            state_d = bus.rw_bit ? RD : WR_PTR;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                WR_PTR: begin
                    if (bus.rx_valid) begin
                        ptr_d     = PTR_W'(bus.rx_byte);
                        ptr_err_d = (32'(bus.rx_byte) >= NUM_REGS);
                        state_d   = WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (bus.rx_valid && !ptr_err_q) begin
                        wr_en_c = 1'b1;
                        ptr_d   = ptr_inc(ptr_q);
                    end
                end
                RD: begin
                    if (bus.tx_req) begin
                        rd_en_c = 1'b1;
                        if (!ptr_err_q) begin
                            ptr_d = ptr_inc(ptr_q);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            ptr_err_q  <= 1'b0;
            tx_valid_q <= 1'b0;
            wr_pulse_q <= 1'b0;
            wr_idx_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            ptr_err_q  <= ptr_err_d;
            tx_valid_q <= rd_en_c;
            wr_pulse_q <= wr_en_c;
            wr_idx_q   <= wr_en_c ? ptr_q : wr_idx_q;
        end
    end

    i2c_reg_array #(
        .NUM_REGS  (NUM_REGS),
        .PTR_W     (PTR_W),
        .RESET_VAL (RESET_VAL)
    ) u_array (
        .clk          (clk),
        .rst          (rst),
        .i2c_we       (wr_en_c),
        .i2c_idx      (ptr_q),
        .i2c_wdata    (bus.rx_byte),
        .host_we      (bus.host_wr),
        .host_idx     (bus.host_addr),
        .host_wdata   (bus.host_wdata),
        .host_raddr   (bus.host_addr),
        .host_rdata_c (host_rdata_c),
        .tx_re        (rd_en_c),
        .tx_idx       (ptr_q),
        .tx_force_oor (ptr_err_q),
        .tx_rdata     (tx_rdata),
        .conflict     (conflict)
    );

    assign bus.tx_byte       = tx_rdata;
    assign bus.tx_valid      = tx_valid_q;
    assign bus.host_rdata    = host_rdata_c;
    assign bus.reg_wr_pulse  = wr_pulse_q;
    assign bus.reg_wr_idx    = wr_idx_q;
    assign bus.ptr_err       = ptr_err_q;
    assign bus.host_conflict = conflict;

endmodule
